// File: rtl/pc_stream_gen.sv
// PC-stream source: linear, looped-window and LFSR pseudo-branch address
// sequences on a valid/ready channel with beat limit, inter-beat gap and abort.
module pc_stream_gen #(
   parameter int XLEN     = 32,
   parameter int STRIDE_W = 12,
   parameter int CNT_W    = 16,
   parameter int GAP_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          mode,
   input  logic [XLEN-1:0]     base,
   input  logic [STRIDE_W-1:0] stride,
   input  logic [CNT_W-1:0]    limit,
   input  logic [CNT_W-1:0]    loop_len,
   input  logic [GAP_W-1:0]    gap,
   output logic [XLEN-1:0]     pc,
   output logic                valid,
   input  logic                ready,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    count
);

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      GAP
   } state_t;

   state_t state, state_nx;

   logic [1:0]          mode_q;
   logic [XLEN-1:0]     base_q;
   logic [STRIDE_W-1:0] stride_q;
   logic [CNT_W-1:0]    limit_q;
   logic [CNT_W-1:0]    loop_len_q;
   logic [GAP_W-1:0]    gap_q;

   logic [XLEN-1:0]  pc_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] idx_q;
   logic [15:0]      lfsr_q;
   logic [GAP_W-1:0] gcnt_q;
   logic             done_q;

   logic             launch;
   logic             accept;
   logic             last;
   logic [CNT_W:0]   cnt_inc;
   logic [CNT_W-1:0] count_nx;
   logic [CNT_W-1:0] idx_inc;
   logic [CNT_W-1:0] idx_nx;
   logic [15:0]      lfsr_adv;
   logic [XLEN-1:0]  seq_pc;
   logic [XLEN-1:0]  jump_pc;
   logic [XLEN-1:0]  pc_nx;

   always_comb begin
      launch   = (state == IDLE) && start && !abort;
      accept   = (state == RUN) && ready;
      cnt_inc  = {1'b0, count_q} + (CNT_W+1)'(1);
      last     = (limit_q != '0) && (cnt_inc == {1'b0, limit_q});
      count_nx = (&count_q) ? count_q : cnt_inc[CNT_W-1:0];
      idx_inc  = idx_q + CNT_W'(1);
      lfsr_adv = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      seq_pc   = pc_q + XLEN'(stride_q);
      jump_pc  = base_q + XLEN'({lfsr_adv[15:4], 2'b00});
      pc_nx    = seq_pc;
      idx_nx   = idx_inc;
      case (mode_q)
         2'b01: begin
            if (loop_len_q != '0 && idx_inc == loop_len_q) begin
               pc_nx  = base_q;
               idx_nx = '0;
            end
         end
         2'b10: begin
            if (lfsr_adv[3:0] == 4'h0)
               pc_nx = jump_pc;
         end
         default: pc_nx = seq_pc;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (launch) state_nx = RUN;
         RUN: begin
            if (abort)
               state_nx = IDLE;
            else if (accept) begin
               if (last)
                  state_nx = IDLE;
               else if (gap_q != '0)
                  state_nx = GAP;
            end
         end
         GAP: begin
            if (abort)
               state_nx = IDLE;
            else if (gcnt_q <= GAP_W'(1))
               state_nx = RUN;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= '0;
         base_q     <= '0;
         stride_q   <= '0;
         limit_q    <= '0;
         loop_len_q <= '0;
         gap_q      <= '0;
         pc_q       <= '0;
         count_q    <= '0;
         idx_q      <= '0;
         lfsr_q     <= LFSR_SEED;
         gcnt_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (launch) begin
            mode_q     <= mode;
            base_q     <= base;
            stride_q   <= stride;
            limit_q    <= limit;
            loop_len_q <= loop_len;
            gap_q      <= gap;
            pc_q       <= base;
            count_q    <= '0;
            idx_q      <= '0;
            lfsr_q     <= LFSR_SEED;
         end else if (accept) begin
            count_q <= count_nx;
            // the final or aborted beat leaves pc on the last address offered
            if (!abort && !last) begin
               pc_q   <= pc_nx;
               idx_q  <= idx_nx;
               gcnt_q <= gap_q;
               if (mode_q == 2'b10)
                  lfsr_q <= lfsr_adv;
            end
            if (!abort && last)
               done_q <= 1'b1;
         end else if (state == GAP && gcnt_q != '0) begin
            gcnt_q <= gcnt_q - GAP_W'(1);
         end
      end
   end

   assign pc    = pc_q;
   assign valid = (state == RUN);
   assign busy  = (state != IDLE);
   assign done  = done_q;
   assign count = count_q;

endmodule
